// File: rtl/alarm_sequencer.sv
// alarm_sequencer: rings, snoozes and times out the user alarm after an alarm-match pulse
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   alarm_enable   level, alarm armed when 1
//   alarm_on       1-cycle alarm-match pulse from the watch core
//   stop_button    debounced level, rising edge stops the alarm
//   snooze_button  debounced level, rising edge snoozes the alarm
//   buzzer         sounder drive
//   ringing        1 while ringing
//   snoozing       1 while snoozing
//   snooze_cnt     snoozes used in the current alarm event
//
// Optional feature macro: ALARM_BEEP_PATTERN_EN (1 s on / 1 s off beeping while ringing)
module alarm_sequencer #(
  parameter int CLKS_PER_SEC = 1,
  parameter int RING_SECS    = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_enable,
  input  logic       alarm_on,
  input  logic       stop_button,
  input  logic       snooze_button,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);
  localparam int PW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [15:0] R_LAST = 16'(RING_SECS - 1);
  localparam logic [15:0] S_LAST = 16'(SNOOZE_SECS - 1);
  localparam logic [1:0] S_MAX = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [15:0] sec_cnt;
  logic stop_prev, snooze_prev, stop_ev, snooze_ev, sec_tick;
  logic [1:0] cnt_nx;

  assign stop_ev   = stop_button & ~stop_prev;
  assign snooze_ev = snooze_button & ~snooze_prev;
  assign sec_tick  = (state != IDLE) && (presc == P_LAST);

  // stop outranks snooze, which outranks the timeout
  always_comb begin
    state_nx = state;
    cnt_nx = snooze_cnt;
    case (state)
      IDLE:
        if (alarm_on && alarm_enable) begin
          state_nx = RING;
          cnt_nx = '0;
        end
      RING:
        if (!alarm_enable || stop_ev) state_nx = IDLE;
        else if (snooze_ev && snooze_cnt < S_MAX) begin
          state_nx = SNOOZE;
          cnt_nx = snooze_cnt + 2'd1;
        end
        else if (sec_tick && sec_cnt == R_LAST) state_nx = IDLE;
      SNOOZE:
        if (!alarm_enable || stop_ev) state_nx = IDLE;
        else if (sec_tick && sec_cnt == S_LAST) state_nx = RING;
      default: state_nx = IDLE;
    endcase
  end

  // timebase restarts on every state change so each ring/snooze gets its full duration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      snooze_cnt <= '0;
      presc <= '0;
      sec_cnt <= '0;
      stop_prev <= 1'b0;
      snooze_prev <= 1'b0;
    end else begin
      state <= state_nx;
      snooze_cnt <= cnt_nx;
      stop_prev <= stop_button;
      snooze_prev <= snooze_button;
      if (state_nx != state) begin
        presc <= '0;
        sec_cnt <= '0;
      end else if (state != IDLE) begin
        presc <= sec_tick ? '0 : presc + PW'(1);
        sec_cnt <= sec_cnt + {15'd0, sec_tick};
      end
    end
  end

  assign ringing  = state == RING;
  assign snoozing = state == SNOOZE;
`ifdef ALARM_BEEP_PATTERN_EN
  assign buzzer = ringing & ~sec_cnt[0];
`else
  assign buzzer = ringing;
`endif
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Controller that sits behind the watch's alarm-match pulse and sequences the user-facing alarm.
- On an enabled alarm match, rings the buzzer for a bounded time.
- Supports a limited number of snooze re-rings, manual stop and auto-timeout.
- Shares the watch's clk and CLKS_PER_SEC timebase; buzzer drives the board sounder.

Parameters:
CLKS_PER_SEC, 1, clk cycles per second (same meaning as the watch core)
RING_SECS, 60, seconds a ring lasts before auto-stop (>=1)
SNOOZE_SECS, 300, snooze wait in seconds before re-ring (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
alarm_enable  input  1  level; alarm armed when 1
alarm_on  input  1  1-cycle pulse from watch core on alarm match
stop_button  input  1  level, synchronous, already debounced; rising edge = stop
snooze_button  input  1  level, synchronous, already debounced; rising edge = snooze
buzzer  output  1  sounder drive
ringing  output  1  1 while in RING
snoozing  output  1  1 while in SNOOZE
snooze_cnt  output  2  snoozes used in current alarm event

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0): state IDLE; all outputs 0; prescaler, second counter and button edge registers cleared.
- Button edges: register previous level each cycle; event = level & ~prev. A button held high produces one event.
- Timebase:
  - Prescaler counts 0..CLKS_PER_SEC-1 only in RING/SNOOZE; sec_tick when it equals CLKS_PER_SEC-1.
  - sec_cnt (16 b) increments on sec_tick.
  - Prescaler and sec_cnt clear to 0 on every state entry, including SNOOZE->RING.
- States: IDLE, RING, SNOOZE. All outputs are decoded from registered state/counters; no input-to-output combinational path.
- IDLE:
  - alarm_on & alarm_enable -> RING; snooze_cnt <= 0.
  - alarm_on with alarm_enable=0 is ignored.
  - ringing/buzzer go high the cycle after the alarm_on sample.
- RING, priority high to low:
  1. alarm_enable=0 -> IDLE.
  2. stop event -> IDLE.
  3. snooze event with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1. At the limit the snooze event is ignored and ringing continues.
  4. sec_tick with sec_cnt == RING_SECS-1 -> IDLE (timeout).
- SNOOZE:
  - buzzer=0.
  - Priority: alarm_enable=0 -> IDLE; stop event -> IDLE; sec_tick with sec_cnt == SNOOZE_SECS-1 -> RING (snooze_cnt kept).
  - Snooze events are ignored.
- alarm_on pulses in RING or SNOOZE are ignored; no restart, no snooze_cnt clear.
- Stop and snooze events in the same cycle: stop wins.
- snooze_cnt holds its value in IDLE until the next alarm start; it saturates at MAX_SNOOZE.
- rst asserted mid-ring or mid-snooze: immediate IDLE, buzzer 0 asynchronously.

Optional Feature:
Macro ALARM_BEEP_PATTERN_EN.
- Defined: in RING, buzzer = ~sec_cnt[0], i.e. 1 s on / 1 s off, starting on.
- Undefined: buzzer = ringing (steady tone).
- The state machine is identical in both builds.

Test Plan:
- Bench config: CLKS_PER_SEC=2, RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2.
- Enabled start: alarm_enable=1, alarm_on pulse -> ringing=1 next cycle; exactly 8 clks later ringing=0, state IDLE, snooze_cnt=0. With ALARM_BEEP_PATTERN_EN: buzzer pattern over those 8 clks is 1,1,0,0,1,1,0,0.
- Disabled ignore: alarm_enable=0, alarm_on pulse -> ringing, snoozing and buzzer stay 0 for 20 clks.
- Snooze cycle: ring, snooze rising edge at clk 3 -> snoozing=1, buzzer=0, snooze_cnt=1; after 6 clks ringing=1 again. Second snooze -> snooze_cnt=2. Third snooze press is ignored (ringing stays 1, snooze_cnt=2) until timeout -> IDLE.
- Stop vs snooze collision: stop and snooze edges in the same cycle during RING -> IDLE, snooze_cnt unchanged. Stop during SNOOZE -> IDLE next cycle. Held stop_button gives one event only.
- Disable and reset: alarm_enable dropped mid-SNOOZE -> IDLE next cycle. rst=0 mid-RING -> buzzer=0 and ringing=0 without waiting for a clk edge. After rst release, a new alarm_on starts a ring with snooze_cnt=0.
- Re-trigger ignore: alarm_on pulse at clk 2 of a ring -> timeout still at clk 8 (no restart).
